// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: stall/flush control, bypass selects and freeze/drain/halt FSM.
// Define HAZARD_PERF_EN to add the stallCnt/flushCnt/freezeCnt performance counters.
module hazard_ctrl #(
  parameter int REG_SIZE     = 5,
  parameter int DRAIN_CYCLES = 2
`ifdef HAZARD_PERF_EN
  , parameter int CNT_W      = 32
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                validD,
  input  logic                validE,
  input  logic                validM,
  input  logic                validW,
  input  logic [REG_SIZE-1:0] raddr1D,
  input  logic [REG_SIZE-1:0] raddr2D,
  input  logic [REG_SIZE-1:0] raddr1E,
  input  logic [REG_SIZE-1:0] raddr2E,
  input  logic                branchD,
  input  logic                controllchangeD,
  input  logic [REG_SIZE-1:0] writeRegE,
  input  logic [REG_SIZE-1:0] writeRegM,
  input  logic [REG_SIZE-1:0] writeRegW,
  input  logic                regWriteE,
  input  logic                regWriteM,
  input  logic                regWriteW,
  input  logic                mem2regE,
  input  logic                mem2regM,
  input  logic                finishE,
  input  logic                memBusyM,
  output logic                stallF,
  output logic                stallD,
  output logic                flushD,
  output logic                flushE,
  output logic [1:0]          forward1,
  output logic [1:0]          forward2,
  output logic [1:0]          forward1E,
  output logic [1:0]          forward2E,
  output logic                halt,
  output logic [1:0]          state
`ifdef HAZARD_PERF_EN
  , output logic [CNT_W-1:0]  stallCnt,
  output logic [CNT_W-1:0]    flushCnt,
  output logic [CNT_W-1:0]    freezeCnt
`endif
);

  typedef enum logic [1:0] {RUN = 2'd0, FREEZE = 2'd1, DRAIN = 2'd2, HALT = 2'd3} state_t;

  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_M    = 2'd1;
  localparam logic [1:0] FWD_W    = 2'd2;
  localparam int         DW       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  // Register 0 is hardwired zero, so a write to it never produces a hazard or bypass.
  function automatic logic hit(input logic v, input logic rw,
                               input logic [REG_SIZE-1:0] wr, input logic [REG_SIZE-1:0] r);
    return v & rw & (wr != '0) & (wr == r);
  endfunction

  logic [REG_SIZE-1:0] src_d [2];
  logic [REG_SIZE-1:0] src_e [2];
  logic [1:0]          e_hit_d;
  logic [1:0]          m_hit_d;
  logic [1:0]          fwd_d [2];
  logic [1:0]          fwd_e [2];
  logic                load_use;
  logic                branch_haz;

  assign src_d[0] = raddr1D;
  assign src_d[1] = raddr2D;
  assign src_e[0] = raddr1E;
  assign src_e[1] = raddr2E;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign e_hit_d[gi] = hit(validE, regWriteE, writeRegE, src_d[gi]);
    assign m_hit_d[gi] = hit(validM, regWriteM, writeRegM, src_d[gi]);
    // Decode never bypasses from W: the regfile writes on negedge, so D already sees it.
    assign fwd_d[gi] = (m_hit_d[gi] & ~mem2regM) ? FWD_M : FWD_NONE;
    assign fwd_e[gi] = (hit(validM, regWriteM, writeRegM, src_e[gi]) & ~mem2regM) ? FWD_M :
                       hit(validW, regWriteW, writeRegW, src_e[gi]) ? FWD_W : FWD_NONE;
  end

  assign load_use   = validD & (|e_hit_d) & mem2regE;
  assign branch_haz = validD & branchD & (|(e_hit_d | (m_hit_d & {2{mem2regM}})));

  state_t        state_reg, state_next;
  logic [DW-1:0] cnt_reg, cnt_next;
  logic          stall_f, stall_d, flush_d, flush_e;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    case (state_reg)
      RUN: begin
        if (memBusyM) begin
          state_next = FREEZE;
          stall_f    = 1'b1;
          stall_d    = 1'b1;
        end else if (finishE) begin
          state_next = DRAIN;
          cnt_next   = '0;
          stall_f    = 1'b1;
          flush_d    = 1'b1;
        end else if (load_use | branch_haz) begin
          // The redirect is dropped here; D re-presents it once the stall clears.
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end else if (controllchangeD) begin
          flush_d = 1'b1;
        end
      end
      FREEZE: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        if (!memBusyM) state_next = RUN;
      end
      DRAIN: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
        if (!memBusyM) begin
          if (cnt_reg == DRAIN_LAST) state_next = HALT;
          else cnt_next = cnt_reg + 1'b1;
        end
      end
      HALT: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

  assign stallF    = reset & stall_f;
  assign stallD    = reset & stall_d;
  assign flushD    = ~reset | flush_d;
  assign flushE    = ~reset | flush_e;
  assign forward1  = reset ? fwd_d[0] : FWD_NONE;
  assign forward2  = reset ? fwd_d[1] : FWD_NONE;
  assign forward1E = reset ? fwd_e[0] : FWD_NONE;
  assign forward2E = reset ? fwd_e[1] : FWD_NONE;
  assign halt      = (state_reg == HALT);
  assign state     = state_reg;

`ifdef HAZARD_PERF_EN
  logic       run_free, hz_stall, cc_flush;
  logic [2:0] perf_ev;

  assign run_free = (state_reg == RUN) & ~memBusyM & ~finishE;
  assign hz_stall = run_free & (load_use | branch_haz);
  assign cc_flush = run_free & ~(load_use | branch_haz) & controllchangeD;
  assign perf_ev  = {state_reg == FREEZE, cc_flush, hz_stall};

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_reg <= '0;
      else if (perf_ev[gi] && state_reg != HALT && !(&cnt_reg)) cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign stallCnt  = g_perf[0].cnt_reg;
  assign flushCnt  = g_perf[1].cnt_reg;
  assign freezeCnt = g_perf[2].cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table of combinational RUN-state vectors plus
// hand-written freeze/drain/halt/reset sequences, compared through an expected-value queue.
module tb_hazard_ctrl;
  localparam logic I = 1'b1;
  localparam logic O = 1'b0;

  typedef struct packed {
    logic vD, vE, vM, vW;
    logic [4:0] r1D, r2D, r1E, r2E;
    logic [4:0] wE, wM, wW;
    logic rwE, rwM, rwW;
    logic lE, lM;
    logic br, cc;
  } in_t;

  typedef struct packed {
    logic sF, sD, fD, fE;
    logic [1:0] f1, f2, f1E, f2E;
    logic [1:0] st;
    logic hl;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic validD, validE, validM, validW;
  logic [4:0] raddr1D, raddr2D, raddr1E, raddr2E;
  logic branchD, controllchangeD;
  logic [4:0] writeRegE, writeRegM, writeRegW;
  logic regWriteE, regWriteM, regWriteW, mem2regE, mem2regM, finishE, memBusyM;
  logic stallF, stallD, flushD, flushE, halt;
  logic [1:0] forward1, forward2, forward1E, forward2E, state;
`ifdef HAZARD_PERF_EN
  logic [31:0] stallCnt, flushCnt, freezeCnt;
`endif

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  string tag_q[$];
  in_t tbl_i [16];
  exp_t tbl_e [16];

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_SIZE(5), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .validD(validD), .validE(validE), .validM(validM), .validW(validW),
    .raddr1D(raddr1D), .raddr2D(raddr2D), .raddr1E(raddr1E), .raddr2E(raddr2E),
    .branchD(branchD), .controllchangeD(controllchangeD),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .mem2regE(mem2regE), .mem2regM(mem2regM), .finishE(finishE), .memBusyM(memBusyM),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .forward1(forward1), .forward2(forward2), .forward1E(forward1E), .forward2E(forward2E),
    .halt(halt), .state(state)
`ifdef HAZARD_PERF_EN
    , .stallCnt(stallCnt), .flushCnt(flushCnt), .freezeCnt(freezeCnt)
`endif
  );

  task automatic drive(input in_t i, input logic busy, input logic fin);
    validD = i.vD; validE = i.vE; validM = i.vM; validW = i.vW;
    raddr1D = i.r1D; raddr2D = i.r2D; raddr1E = i.r1E; raddr2E = i.r2E;
    writeRegE = i.wE; writeRegM = i.wM; writeRegW = i.wW;
    regWriteE = i.rwE; regWriteM = i.rwM; regWriteW = i.rwW;
    mem2regE = i.lE; mem2regM = i.lM; branchD = i.br; controllchangeD = i.cc;
    memBusyM = busy; finishE = fin;
  endtask

  function automatic exp_t sample();
    exp_t a;
    a = {stallF, stallD, flushD, flushE, forward1, forward2, forward1E, forward2E, state, halt};
    return a;
  endfunction

  task automatic compare(input string tag, input exp_t a, input exp_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got sF sD fD fE f1 f2 f1E f2E st hl = %b required %b", tag, a, e);
    end else begin
      $display("ok   %s: %b", tag, a);
    end
  endtask

  // Drive one cycle's inputs after the edge, queue the expectation, compare at the negedge.
  task automatic step(input in_t i, input logic busy, input logic fin, input exp_t e, input string tag);
    exp_t ee;
    string tt;
    @(posedge clk);
    #1;
    drive(i, busy, fin);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    ee = exp_q.pop_front();
    tt = tag_q.pop_front();
    compare(tt, sample(), ee);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t  idle, seq_d, seq_e;
    exp_t zero, e_rst, e_stall, e_frz0, e_frz, e_fin, e_drn, e_halt, e_fw;

    idle    = '0;
    zero    = '0;
    e_rst   = '{O, O, I, I, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, O};
    e_stall = '{I, I, O, I, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, O};
    e_frz0  = '{I, I, O, O, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, O};
    e_frz   = '{I, I, O, O, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, O};
    e_fin   = '{I, O, I, O, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, O};
    e_drn   = '{I, I, O, I, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, O};
    e_halt  = '{I, I, I, I, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, I};
    e_fw    = '{O, O, O, O, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, O};

    //            vD vE vM vW  r1D    r2D    r1E    r2E    wE     wM     wW     rwE rwM rwW lE lM br cc
    tbl_i[0]  = '{O, O, O, O, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  O, O, O, O, O, O, O};
    tbl_e[0]  = zero;
    tbl_i[1]  = '{I, I, O, O, 5'd5,  5'd1,  5'd0,  5'd0,  5'd5,  5'd0,  5'd0,  I, O, O, I, O, O, O};
    tbl_e[1]  = e_stall;
    tbl_i[2]  = '{I, I, O, O, 5'd5,  5'd1,  5'd0,  5'd0,  5'd5,  5'd0,  5'd0,  I, O, O, I, O, O, I};
    tbl_e[2]  = e_stall;
    tbl_i[3]  = '{O, I, I, I, 5'd3,  5'd0,  5'd3,  5'd3,  5'd0,  5'd3,  5'd3,  O, I, I, O, O, O, O};
    tbl_e[3]  = '{O, O, O, O, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0, O};
    tbl_i[4]  = '{O, I, I, I, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  O, I, I, O, O, O, O};
    tbl_e[4]  = zero;
    tbl_i[5]  = '{O, O, O, I, 5'd7,  5'd0,  5'd7,  5'd2,  5'd0,  5'd0,  5'd7,  O, O, I, O, O, O, O};
    tbl_e[5]  = '{O, O, O, O, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, O};
    tbl_i[6]  = '{O, O, I, I, 5'd0,  5'd9,  5'd0,  5'd9,  5'd0,  5'd9,  5'd9,  O, I, I, O, I, O, O};
    tbl_e[6]  = '{O, O, O, O, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, O};
    tbl_i[7]  = '{O, O, O, O, 5'd4,  5'd0,  5'd4,  5'd0,  5'd0,  5'd4,  5'd0,  O, I, O, O, O, O, O};
    tbl_e[7]  = zero;
    tbl_i[8]  = '{I, I, O, O, 5'd4,  5'd0,  5'd0,  5'd0,  5'd4,  5'd0,  5'd0,  I, O, O, O, O, I, O};
    tbl_e[8]  = e_stall;
    tbl_i[9]  = '{I, O, I, O, 5'd4,  5'd0,  5'd0,  5'd0,  5'd0,  5'd4,  5'd0,  O, I, O, O, O, I, I};
    tbl_e[9]  = '{O, O, I, O, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, O};
    tbl_i[10] = '{I, O, I, O, 5'd0,  5'd8,  5'd0,  5'd0,  5'd0,  5'd8,  5'd0,  O, I, O, O, I, I, O};
    tbl_e[10] = e_stall;
    tbl_i[11] = '{I, I, O, O, 5'd6,  5'd0,  5'd0,  5'd0,  5'd6,  5'd0,  5'd0,  I, O, O, O, O, O, O};
    tbl_e[11] = zero;
    tbl_i[12] = '{O, I, O, O, 5'd5,  5'd0,  5'd0,  5'd0,  5'd5,  5'd0,  5'd0,  I, O, O, I, O, O, O};
    tbl_e[12] = zero;
    tbl_i[13] = '{I, O, O, O, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  O, O, O, O, O, O, I};
    tbl_e[13] = '{O, O, I, O, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, O};
    tbl_i[14] = '{I, I, O, O, 5'd5,  5'd0,  5'd0,  5'd0,  5'd5,  5'd0,  5'd0,  O, O, O, I, O, O, O};
    tbl_e[14] = zero;
    tbl_i[15] = '{I, I, O, O, 5'd0,  5'd3,  5'd0,  5'd0,  5'd3,  5'd0,  5'd0,  I, O, O, O, O, I, O};
    tbl_e[15] = e_stall;

    // Reset asserted with hazard, bypass, busy and finish inputs all active.
    reset = 1'b0;
    drive(tbl_i[3], I, I);
    validD = 1'b1; mem2regE = 1'b1; validE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd3;
    #7;
    compare("reset_outputs", sample(), e_rst);
    @(negedge clk);
    compare("reset_held", sample(), e_rst);
    drive(idle, O, O);
    release_reset();

    for (int k = 0; k < 16; k++) step(tbl_i[k], O, O, tbl_e[k], $sformatf("vec%0d", k));

    // lw x5 / add x6,x5,x1: one stall cycle, then the add reads x5 from W.
    seq_d = '{I, O, I, O, 5'd5, 5'd1, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, O, I, O, O, I, O, O};
    seq_e = '{O, I, O, I, 5'd0, 5'd0, 5'd5, 5'd1, 5'd0, 5'd0, 5'd5, O, O, I, O, O, O, O};
    step(tbl_i[1], O, O, e_stall, "lu_stall");
    step(seq_d, O, O, zero, "lu_release");
    step(seq_e, O, O, e_fw, "lu_fwd_w");

    // Data memory busy for three cycles.
    step(idle, I, O, e_frz0, "frz_enter");
    step(tbl_i[1], I, O, e_frz, "frz_1");
    step(idle, I, O, e_frz, "frz_2");
    step(idle, O, O, e_frz, "frz_3");
    step(idle, O, O, zero, "frz_exit");

    // Drain with a busy cycle in the middle, then sticky halt.
    step(idle, O, I, e_fin, "fin_enter");
    step(idle, O, O, e_drn, "drain_0");
    step(idle, I, O, e_drn, "drain_hold");
    step(idle, O, O, e_drn, "drain_1");
    step(tbl_i[1], I, I, e_halt, "halt_0");
    step(tbl_i[13], O, O, e_halt, "halt_sticky");
    #2;
    reset = 1'b0;
    #1;
    compare("rst_async_halt", sample(), e_rst);
    drive(idle, O, O);
    release_reset();

    // Plain drain: exactly two DRAIN cycles.
    step(idle, O, I, e_fin, "fin2_enter");
    step(idle, O, O, e_drn, "drain2_0");
    step(idle, O, O, e_drn, "drain2_1");
    step(idle, O, O, e_halt, "halt2");

    // Reset during FREEZE returns to RUN without a clock edge.
    reset = 1'b0;
    #1;
    compare("rst_async_halt2", sample(), e_rst);
    release_reset();
    step(idle, I, O, e_frz0, "frz2_enter");
    step(idle, I, O, e_frz, "frz2_1");
    #1;
    reset = 1'b0;
    #1;
    compare("rst_async_frz", sample(), e_rst);
    drive(idle, O, O);
    release_reset();
    step(idle, O, O, zero, "run_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
